// File: rtl/address_generator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : address_generator_pkg
//  Description : Shared mode codes, defaults and LFSR tap table for the
//                BIST address generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package address_generator_pkg;

    localparam logic [1:0] ADMD_LIUD = 2'b00;
    localparam logic [1:0] ADMD_PRUD = 2'b01;
    localparam logic [1:0] ADMD_AC   = 2'b10;
    localparam logic [1:0] ADMD_RC   = 2'b11;

    localparam logic ADDR_UP = 1'b0;

    localparam int DEFAULT_ADDR_WIDTH = 8;
    localparam int ADMD_PR_SEED       = 1;

    // Maximal-length tap masks over count[w-1:0]; bit w-1 is always set,
    // which the reverse LFSR step relies on.
    function automatic logic [15:0] default_pr_taps(input int w);
        logic [15:0] taps;
        case (w)
            4:       taps = 16'h000C;
            5:       taps = 16'h0014;
            6:       taps = 16'h0030;
            7:       taps = 16'h0060;
            8:       taps = 16'h00B8;
            9:       taps = 16'h0110;
            10:      taps = 16'h0240;
            11:      taps = 16'h0500;
            12:      taps = 16'h0829;
            13:      taps = 16'h100D;
            14:      taps = 16'h2015;
            15:      taps = 16'h6000;
            16:      taps = 16'hD008;
            default: taps = 16'h00B8;
        endcase
        return taps;
    endfunction

endpackage
`default_nettype wire

// File: rtl/address_generator_lfsr_step.sv
`default_nettype none
// ============================================================================
//  Module      : addr_lfsr_step
//  Description : Combinational de Bruijn LFSR next state, forward or reverse.
//  Revision    : 1.0 - initial release
// ============================================================================
module addr_lfsr_step
    import address_generator_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] PR_TAPS    = ADDR_WIDTH'(default_pr_taps(ADDR_WIDTH))
)(
    input  logic [ADDR_WIDTH-1:0] count_in,
    input  logic                  dir_in,
    output logic [ADDR_WIDTH-1:0] next_out
);

    logic                  fb_up;
    logic                  msb_dn;
    logic [ADDR_WIDTH-1:0] next_up;
    logic [ADDR_WIDTH-1:0] next_dn;

    always_comb begin
        // Zero-detect term splices the all-zero state into the cycle.
        fb_up   = (^(count_in & PR_TAPS)) ^ (count_in[ADDR_WIDTH-2:0] == '0);
        next_up = {count_in[ADDR_WIDTH-2:0], fb_up};

        // Reverse step solves the feedback equation for the shifted-out MSB.
        msb_dn  = count_in[0]
                ^ (^(count_in[ADDR_WIDTH-1:1] & PR_TAPS[ADDR_WIDTH-2:0]))
                ^ (count_in[ADDR_WIDTH-1:1] == '0);
        next_dn = {msb_dn, count_in[ADDR_WIDTH-1:1]};

        next_out = (dir_in == ADDR_UP) ? next_up : next_dn;
    end

endmodule
`default_nettype wire

// File: rtl/address_generator.sv
`default_nettype none
// ============================================================================
//  Module      : address_generator
//  Description : Parametrised march-test address sequencer (linear, PR,
//                address-complement, row-fast) with last/done flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module address_generator
    import address_generator_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int                    ROW_WIDTH  = 4,
    parameter logic [ADDR_WIDTH-1:0] PR_TAPS    = ADDR_WIDTH'(default_pr_taps(ADDR_WIDTH)),
    parameter logic [ADDR_WIDTH-1:0] PR_SEED    = ADDR_WIDTH'(ADMD_PR_SEED)
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            admd_in,
    input  logic                  updwn_in,
    input  logic                  start_in,
    input  logic                  step_in,
    output logic [ADDR_WIDTH-1:0] tas_out,
    output logic                  last_out,
    output logic                  done_out
);

    localparam int COLW = ADDR_WIDTH - ROW_WIDTH;

    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic [ADDR_WIDTH-1:0] first_q, first_d;
    logic                  done_q, done_d;

    logic [ADDR_WIDTH-1:0] pr_next_upd;
    logic [ADDR_WIDTH-1:0] pr_next_look;
    logic [ADDR_WIDTH-1:0] lin_next;
    logic [ADDR_WIDTH-1:0] next_upd;
    logic [ADDR_WIDTH-1:0] next_look;
    logic [ADDR_WIDTH-1:0] first_state;
    logic [ADDR_WIDTH-1:0] ac_base;
    logic                  last;

    addr_lfsr_step #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .PR_TAPS    (PR_TAPS)
    ) u_lfsr_upd (
        .count_in (count_q),
        .dir_in   (updwn_in),
        .next_out (pr_next_upd)
    );

    // Separate copy keeps the last_out lookahead off the count-update mux.
    addr_lfsr_step #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .PR_TAPS    (PR_TAPS)
    ) u_lfsr_look (
        .count_in (count_q),
        .dir_in   (updwn_in),
        .next_out (pr_next_look)
    );

    always_comb begin
        lin_next    = (updwn_in == ADDR_UP) ? (count_q + ADDR_WIDTH'(1))
                                            : (count_q - ADDR_WIDTH'(1));
        next_upd    = (admd_in == ADMD_PRUD) ? pr_next_upd  : lin_next;
        next_look   = (admd_in == ADMD_PRUD) ? pr_next_look : lin_next;
        first_state = (admd_in == ADMD_PRUD) ? PR_SEED
                    : ((updwn_in == ADDR_UP) ? '0 : '1);
        last        = (next_look == first_q);
    end

    always_comb begin
        count_d = count_q;
        first_d = first_q;
        done_d  = done_q;
        if (start_in) begin
            count_d = first_state;
            first_d = first_state;
            done_d  = 1'b0;
        end else if (step_in) begin
            count_d = next_upd;
            if (last) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            first_q <= '0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            first_q <= first_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        ac_base = {1'b0, count_q[ADDR_WIDTH-1:1]};
        case (admd_in)
            ADMD_AC: tas_out = count_q[0] ? ~ac_base : ac_base;
            ADMD_RC: tas_out = {count_q[ROW_WIDTH-1:0], count_q[ROW_WIDTH +: COLW]};
            default: tas_out = count_q;
        endcase
    end

    assign last_out = last;
    assign done_out = done_q;

endmodule
`default_nettype wire

// File: tb/tb_address_generator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_address_generator
//  Description : Directed self-checking bench for address_generator (AW=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_address_generator;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] admd_in = 2'b00;
    logic       updwn_in = 1'b0;
    logic       start_in = 1'b0;
    logic       step_in = 1'b0;
    logic [7:0] tas_out;
    logic       last_out;
    logic       done_out;

    int n_cmp = 0;
    int n_err = 0;

    address_generator #(
        .ADDR_WIDTH (8),
        .ROW_WIDTH  (4),
        .PR_TAPS    (8'hB8),
        .PR_SEED    (8'h01)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .admd_in  (admd_in),
        .updwn_in (updwn_in),
        .start_in (start_in),
        .step_in  (step_in),
        .tas_out  (tas_out),
        .last_out (last_out),
        .done_out (done_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [1:0] md, input logic dir);
        admd_in  = md;
        updwn_in = dir;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
    endtask

    logic [7:0] pr_exp [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
    logic [7:0] ac_exp [5] = '{8'h00, 8'hFF, 8'h01, 8'hFE, 8'h02};
    bit         seen [256];
    int         dups;
    int         n;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        tick();
        check("rst_tas", tas_out, 8'h00);
        check("rst_last", last_out, 1'b0);
        check("rst_done", done_out, 1'b0);
        #2 rst = 1'b1;

        // LIUD up: full sweep, wrap and done
        do_start(2'b00, 1'b0);
        step_in = 1'b1;
        for (int i = 0; i < 256; i++) begin
            check("liud_tas", tas_out, 16'(i));
            check("liud_last", last_out, (i == 255) ? 16'd1 : 16'd0);
            if (i == 255) check("liud_done_pre", done_out, 1'b0);
            tick();
        end
        step_in = 1'b0;
        check("liud_wrap_tas", tas_out, 8'h00);
        check("liud_done", done_out, 1'b1);

        // PRUD up: known prefix, full coverage, passage via 80 -> 00
        do_start(2'b01, 1'b0);
        check("pr_done_clr", done_out, 1'b0);
        dups = 0;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        step_in = 1'b1;
        for (int i = 0; i < 256; i++) begin
            if (i < 8) check("pr_up_tas", tas_out, pr_exp[i]);
            if (i == 254) check("pr_via80", tas_out, 8'h80);
            if (i == 255) check("pr_via00", tas_out, 8'h00);
            if (seen[tas_out]) dups++;
            seen[tas_out] = 1'b1;
            check("pr_last", last_out, (i == 255) ? 16'd1 : 16'd0);
            tick();
        end
        step_in = 1'b0;
        check("pr_dups", 16'(dups), 16'd0);
        check("pr_wrap_tas", tas_out, 8'h01);
        check("pr_done", done_out, 1'b1);

        // PRUD down from seed
        do_start(2'b01, 1'b1);
        check("prd_start", tas_out, 8'h01);
        check("prd_last", last_out, 1'b0);
        step_in = 1'b1;
        tick();
        check("prd_s1", tas_out, 8'h00);
        tick();
        check("prd_s2", tas_out, 8'h80);
        step_in = 1'b0;

        // Down n then up n returns to the seed
        for (int k = 0; k < 100; k++) begin
            do_start(2'b01, 1'b1);
            n = int'($urandom_range(1, 200));
            step_in = 1'b1;
            repeat (n) tick();
            updwn_in = 1'b0;
            repeat (n) tick();
            step_in = 1'b0;
            check("pr_roundtrip", tas_out, 8'h01);
        end

        // AC up / down
        do_start(2'b10, 1'b0);
        step_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("ac_up", tas_out, ac_exp[i]);
            tick();
        end
        step_in = 1'b0;
        do_start(2'b10, 1'b1);
        check("ac_dn_start", tas_out, 8'h80);
        check("ac_dn_last", last_out, 1'b0);
        step_in = 1'b1;
        tick();
        step_in = 1'b0;
        check("ac_dn_s1", tas_out, 8'h7F);

        // RC up: row field moves fastest
        do_start(2'b11, 1'b0);
        check("rc_start", tas_out, 8'h00);
        step_in = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("rc_up", tas_out, (i < 16) ? 16'(i << 4) : 16'h01);
        end
        repeat (239) tick();
        check("rc_final_tas", tas_out, 8'hFF);
        check("rc_final_last", last_out, 1'b1);
        tick();
        check("rc_wrap_tas", tas_out, 8'h00);
        check("rc_done", done_out, 1'b1);
        repeat (5) tick();
        check("rc_repeat_tas", tas_out, 8'h50);
        check("rc_repeat_done", done_out, 1'b1);
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        step_in  = 1'b0;
        check("rc_start_step_tas", tas_out, 8'h00);
        check("rc_start_step_done", done_out, 1'b0);

        // Asynchronous reset mid-sequence
        do_start(2'b00, 1'b0);
        step_in = 1'b1;
        repeat (266) tick();
        step_in = 1'b0;
        check("ar_pre_tas", tas_out, 8'h0A);
        check("ar_pre_done", done_out, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("ar_tas", tas_out, 8'h00);
        check("ar_done", done_out, 1'b0);
        check("ar_last", last_out, 1'b0);
        #1 rst = 1'b1;
        step_in = 1'b1;
        tick();
        check("ar_step1", tas_out, 8'h01);
        tick();
        step_in = 1'b0;
        check("ar_step2", tas_out, 8'h02);
        check("ar_step_done", done_out, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
